// File: rtl/gt_bist_pkg.sv
// gt_bist_pkg: shared state encoding and sweep sizing helpers for greater_than_bist
package gt_bist_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    function automatic int vector_count(input int width);
        return 2 ** (2 * width);
    endfunction

    function automatic int sweep_cycles(input int width, input int settle);
        return vector_count(width) * (settle + 1);
    endfunction

endpackage

// File: rtl/greater_than_bist_operand_sweep_counter.sv
// operand_sweep_counter: walks every {a, b} pair with b as the fast-moving half
module operand_sweep_counter
    import gt_bist_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             last
);

    logic [2*WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (advance)
            cnt <= cnt + 1'b1;
    end

    assign {a, b} = cnt;
    assign last   = &cnt;

endmodule

// File: rtl/greater_than_bist.sv
// greater_than_bist: exhaustive self-test of a greater-than comparator,
// counting mismatches against a > b and capturing the first failing pair.
module greater_than_bist
    import gt_bist_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               dut_out,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               first_err_valid,
    output logic [WIDTH-1:0]   first_err_a,
    output logic [WIDTH-1:0]   first_err_b
);

    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_t          state, next;
    logic [SW-1:0]   settle_cnt;
    logic            last, start_sweep, mismatch;

    assign start_sweep = start && (state == IDLE || state == DONE);
    assign mismatch    = state == CHECK && dut_out != (a > b);

    operand_sweep_counter #(.WIDTH(WIDTH)) u_sweep (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_sweep),
        .advance(state == CHECK && !last),
        .a      (a),
        .b      (b),
        .last   (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE, DONE: next = start ? DRIVE : state;
            DRIVE:      next = settle_cnt == SETTLE_LAST ? CHECK : DRIVE;
            CHECK:      next = last ? DONE : DRIVE;
            default:    next = IDLE;
        endcase
    end

    // The settle counter restarts whenever a vector is (re)entered in DRIVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            settle_cnt <= '0;
        else if (start_sweep || state == CHECK)
            settle_cnt <= '0;
        else if (state == DRIVE)
            settle_cnt <= settle_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
        end else if (start_sweep) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
        end else if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_a     <= a;
                first_err_b     <= b;
            end
        end
    end

    assign busy = state == DRIVE || state == CHECK;
    assign done = state == DONE;
    assign pass = done && err_count == '0;

endmodule

// File: tb/tb_greater_than_bist.sv
// tb_greater_than_bist: table-driven sweeps of two BIST instances against
// golden, stuck-at-0 and inverted comparator models, plus reset corner cases.
module tb_greater_than_bist;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic sel = 1'b0;
    int   mode = 0;

    logic [1:0] a2, b2, fa2, fb2;
    logic [4:0] e2;
    logic       busy2, done2, pass2, fv2, d2;
    logic [2:0] a3, b3, fa3, fb3;
    logic [6:0] e3;
    logic       busy3, done3, pass3, fv3, d3;

    logic [2:0] ca, cb, cfa, cfb;
    logic [6:0] cerr;
    logic       cbusy, cdone, cpass, cfv;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign d2 = mode == 0 ? (a2 > b2) : mode == 2 ? !(a2 > b2) : 1'b0;
    assign d3 = mode == 0 ? (a3 > b3) : mode == 2 ? !(a3 > b3) : 1'b0;

    greater_than_bist #(.WIDTH(2), .SETTLE_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .start(start && !sel), .dut_out(d2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(e2), .first_err_valid(fv2), .first_err_a(fa2), .first_err_b(fb2)
    );

    greater_than_bist #(.WIDTH(3), .SETTLE_CYCLES(2)) dut3 (
        .clk(clk), .rst(rst), .start(start && sel), .dut_out(d3),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(e3), .first_err_valid(fv3), .first_err_a(fa3), .first_err_b(fb3)
    );

    assign ca    = sel ? a3 : {1'b0, a2};
    assign cb    = sel ? b3 : {1'b0, b2};
    assign cfa   = sel ? fa3 : {1'b0, fa2};
    assign cfb   = sel ? fb3 : {1'b0, fb2};
    assign cerr  = sel ? e3 : {2'b0, e2};
    assign cbusy = sel ? busy3 : busy2;
    assign cdone = sel ? done3 : done2;
    assign cpass = sel ? pass3 : pass2;
    assign cfv   = sel ? fv3 : fv2;

    typedef struct {
        string name;
        int    mode;
        bit    sel;
        bit    poke;
        int    exp_err;
        int    exp_fa;
        int    exp_fb;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full sweep; the scoreboard queue holds the {a,b} pair expected per vector.
    task automatic run(input vec_t t);
        int w, per, n;
        logic [5:0] q[$];
        logic [5:0] exp;
        bit ok;
        w   = t.sel ? 3 : 2;
        per = t.sel ? 3 : 2;
        n   = 1 << (2 * w);
        mode = t.mode;
        sel  = t.sel;
        for (int i = 0; i < n; i++)
            q.push_back({3'(i >> w), 3'(i & ((1 << w) - 1))});
        @(negedge clk) start = 1'b1;
        ok = 1'b1;
        for (int v = 0; v < n; v++) begin
            exp = q.pop_front();
            for (int c = 0; c < per; c++) begin
                @(negedge clk);
                start = t.poke && v == 3 && c == 0;
                if (v == 0 && c == 0) begin
                    chk({t.name, " cleared err_count"}, cerr, 0);
                    chk({t.name, " cleared first_err_valid"}, cfv, 0);
                end
                if (ca != exp[5:3] || cb != exp[2:0] || !cbusy || cdone) begin
                    if (ok)
                        $display("FAIL %s vector %0d cycle %0d: a=%0d b=%0d busy=%0d done=%0d expected a=%0d b=%0d busy=1 done=0",
                                 t.name, v, c, ca, cb, cbusy, cdone, exp[5:3], exp[2:0]);
                    ok = 1'b0;
                end
            end
        end
        tests++;
        if (!ok) fails++;
        @(negedge clk);
        chk({t.name, " done"}, cdone, 1);
        chk({t.name, " busy"}, cbusy, 0);
        chk({t.name, " pass"}, cpass, t.exp_err == 0);
        chk({t.name, " err_count"}, cerr, t.exp_err);
        chk({t.name, " first_err_valid"}, cfv, t.exp_err != 0);
        chk({t.name, " first_err_a"}, cfa, t.exp_fa);
        chk({t.name, " first_err_b"}, cfb, t.exp_fb);
        chk({t.name, " final a"}, ca, (1 << w) - 1);
        chk({t.name, " final b"}, cb, (1 << w) - 1);
        repeat (2) @(negedge clk);
        chk({t.name, " done held"}, cdone, 1);
    endtask

    task automatic chk_zero(input string name);
        chk({name, " a"}, a2, 0);
        chk({name, " b"}, b2, 0);
        chk({name, " busy"}, busy2, 0);
        chk({name, " done"}, done2, 0);
        chk({name, " pass"}, pass2, 0);
        chk({name, " err_count"}, e2, 0);
        chk({name, " first_err_valid"}, fv2, 0);
        chk({name, " first_err_a"}, fa2, 0);
        chk({name, " first_err_b"}, fb2, 0);
    endtask

    vec_t tab[6];

    initial begin
        tab[0] = '{"golden",      0, 1'b0, 1'b0, 0,  0, 0};
        tab[1] = '{"stuck0",      1, 1'b0, 1'b0, 6,  1, 0};
        tab[2] = '{"inverted",    2, 1'b0, 1'b0, 16, 0, 0};
        tab[3] = '{"restart_poke",0, 1'b0, 1'b1, 0,  0, 0};
        tab[4] = '{"w3_stuck0",   1, 1'b1, 1'b0, 28, 1, 0};
        tab[5] = '{"w3_golden",   0, 1'b1, 1'b1, 0,  0, 0};

        repeat (2) @(negedge clk);
        chk_zero("reset");
        chk("reset w3 busy", busy3, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle without start", busy2, 0);

        foreach (tab[i]) run(tab[i]);

        // Dirty a sweep, then reset asynchronously between edges 11 and 12.
        mode = 1;
        sel  = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        chk("pre-reset err_count", e2, 1);
        rst = 1'b1;
        #1;
        chk_zero("async reset");
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        chk("reset beats start busy", busy2, 0);
        start = 1'b0;
        rst   = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle after reset", busy2 | done2, 0);
        run(tab[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
